// File: rtl/pu_msp430_reset_sequencer_if.sv
// Reset sequencer signal bundle.
//   Requests, enables and cause clear flow from the reset sources (master)
//   into the sequencer (slave); sequenced domain resets, the sticky cause
//   record and the busy flag flow back out.
//   req_a      NUM_REQ      asynchronous reset requests, level, active-high
//   req_mask   NUM_REQ      1 = request enabled, quasi-static
//   cause_clr  1            single-cycle pulse, clears cause_o
//   rst_dom_o  NUM_DOMAINS  domain resets, active-high
//   cause_o    NUM_REQ      sticky record of enabled requests that fired
//   busy_o     1            high while any domain reset is asserted
interface pu_msp430_reset_sequencer_if #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned NUM_DOMAINS = 3
) ();

   logic [NUM_REQ-1:0]     req_a;
   logic [NUM_REQ-1:0]     req_mask;
   logic                   cause_clr;
   logic [NUM_DOMAINS-1:0] rst_dom_o;
   logic [NUM_REQ-1:0]     cause_o;
   logic                   busy_o;

   modport master (
      output req_a,
      output req_mask,
      output cause_clr,
      input  rst_dom_o,
      input  cause_o,
      input  busy_o
   );

   modport slave (
      input  req_a,
      input  req_mask,
      input  cause_clr,
      output rst_dom_o,
      output cause_o,
      output busy_o
   );

endinterface

// File: rtl/pu_msp430_reset_sequencer.sv
// Parametrised reset sequencer.
//   Synchronises NUM_REQ asynchronous reset requests into clk, holds every
//   domain reset for at least STRETCH_CYCLES quiet edges, then releases the
//   NUM_DOMAINS domain resets one by one in index order, RELEASE_GAP edges
//   apart. A sticky cause register records which enabled requests fired.
// Ports:
//   clk  receiving clock
//   rst  master reset, synchronous, active-high
//   bus  slave side of pu_msp430_reset_sequencer_if (requests in, domain
//        resets / cause / busy out; all outputs come straight from flops)
module pu_msp430_reset_sequencer #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned STRETCH_CYCLES = 16,
   parameter int unsigned NUM_DOMAINS    = 3,
   parameter int unsigned RELEASE_GAP    = 4
) (
   input logic                       clk,
   input logic                       rst,
   pu_msp430_reset_sequencer_if.slave bus
);

   localparam int unsigned CntMax = (STRETCH_CYCLES > RELEASE_GAP) ? STRETCH_CYCLES : RELEASE_GAP;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] StretchLast = CntW'(STRETCH_CYCLES);
   localparam logic [CntW-1:0] GapLast     = CntW'(RELEASE_GAP);
   localparam logic [CntW-1:0] CntOne      = CntW'(1);

   typedef enum logic [1:0] {StAssert, StStretch, StRelease, StRun} state_e;

   logic [SYNC_STAGES-1:0][NUM_REQ-1:0] sync_q;
   logic [NUM_REQ-1:0]                  req_s;
   logic [NUM_REQ-1:0]                  req_en;
   logic                                any_req;

   state_e                 state_q;
   logic [CntW-1:0]        cnt_q;
   logic [NUM_DOMAINS-1:0] dom_q;
   logic [NUM_DOMAINS-1:0] dom_shift;
   logic [NUM_REQ-1:0]     cause_q;
   logic                   busy_q;

   assign req_s   = sync_q[SYNC_STAGES-1];
   assign req_en  = req_s & bus.req_mask;
   assign any_req = |req_en;

   // Domains are released lowest index first, so the next pattern is the
   // current one shifted up by one; all zeros means the last domain is out.
   assign dom_shift = dom_q << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= StStretch;
         cnt_q   <= '0;
         dom_q   <= '1;
         busy_q  <= 1'b1;
         cause_q <= '0;
      end else begin
         sync_q[0] <= bus.req_a;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end

         // A new cause wins over a simultaneous clear.
         cause_q <= (bus.cause_clr ? '0 : cause_q) | req_en;

         unique case (state_q)
            StAssert: begin
               // This edge is the first quiet one, so it already counts.
               if (!any_req) begin
                  state_q <= StStretch;
                  cnt_q   <= CntOne;
               end
            end

            StStretch: begin
               if (any_req) begin
                  state_q <= StAssert;
                  cnt_q   <= '0;
               end else if (cnt_q == StretchLast) begin
                  dom_q <= dom_shift;
                  cnt_q <= CntOne;
                  if (dom_shift == '0) begin
                     state_q <= StRun;
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= StRelease;
                  end
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end

            StRelease: begin
               if (any_req) begin
                  dom_q   <= '1;
                  state_q <= StAssert;
                  cnt_q   <= '0;
               end else if (cnt_q == GapLast) begin
                  dom_q <= dom_shift;
                  cnt_q <= CntOne;
                  if (dom_shift == '0) begin
                     state_q <= StRun;
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end

            StRun: begin
               if (any_req) begin
                  dom_q   <= '1;
                  busy_q  <= 1'b1;
                  state_q <= StAssert;
                  cnt_q   <= '0;
               end
            end
         endcase
      end
   end

   assign bus.rst_dom_o = dom_q;
   assign bus.cause_o   = cause_q;
   assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_pu_msp430_reset_sequencer.sv
// Bench for pu_msp430_reset_sequencer: directed scenarios plus a random run,
// checked against a behavioural model that derives the domain resets from
// the number of consecutive quiet edges since the last enabled request.
module tb_pu_msp430_reset_sequencer;

   localparam int NReq    = 4;
   localparam int Sync    = 2;
   localparam int Stretch = 16;
   localparam int NDom    = 3;
   localparam int Gap     = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pu_msp430_reset_sequencer_if #(.NUM_REQ(NReq), .NUM_DOMAINS(NDom)) bus ();

   pu_msp430_reset_sequencer #(
      .NUM_REQ       (NReq),
      .SYNC_STAGES   (Sync),
      .STRETCH_CYCLES(Stretch),
      .NUM_DOMAINS   (NDom),
      .RELEASE_GAP   (Gap)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference model: request samples age through a queue of Sync entries;
   // quiet counts consecutive edges with no enabled synchronised request.
   // Domain 0 is released on quiet edge Stretch+1, the rest every Gap edges.
   logic [NReq-1:0] pipe [$];
   int              quiet = 0;
   logic [NReq-1:0] m_cause = '0;
   logic [NDom-1:0] m_dom = '1;
   logic            m_busy = 1'b1;

   always @(posedge clk) begin
      logic [NReq-1:0] s;
      int              rel;
      if (rst) begin
         pipe.delete();
         for (int i = 0; i < Sync; i++) pipe.push_back('0);
         quiet   = 0;
         m_cause = '0;
      end else begin
         s = pipe.pop_front() & bus.req_mask;
         pipe.push_back(bus.req_a);
         m_cause = (bus.cause_clr ? '0 : m_cause) | s;
         if (s != '0) quiet = 0;
         else if (quiet < 100000) quiet = quiet + 1;
      end
      rel = 0;
      if (quiet >= Stretch + 1) rel = 1 + (quiet - Stretch - 1) / Gap;
      if (rel > NDom) rel = NDom;
      m_dom  = '1;
      m_dom  = m_dom << rel;
      m_busy = |m_dom;
   end

   task automatic test_reset();
      logic [NDom-1:0] exp;
      rst           = 1'b1;
      bus.req_a     = '0;
      bus.req_mask  = '1;
      bus.cause_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.rst_dom_o !== 3'b111 || bus.busy_o !== 1'b1 || bus.cause_o !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: dom=%b busy=%b cause=%h, want dom=111 busy=1 cause=0",
                  bus.rst_dom_o, bus.busy_o, bus.cause_o);
      end
      rst = 1'b0;
      for (int e = 0; e <= 28; e++) begin
         @(negedge clk);
         exp = (e < 16) ? 3'b111 : (e < 20) ? 3'b110 : (e < 24) ? 3'b100 : 3'b000;
         checks++;
         if (bus.rst_dom_o !== exp || bus.busy_o !== (e < 24) || bus.cause_o !== 4'h0) begin
            errors++;
            $display("FAIL powerup E0+%0d: dom=%b busy=%b cause=%h, want dom=%b busy=%b cause=0",
                     e, bus.rst_dom_o, bus.busy_o, bus.cause_o, exp, (e < 24));
         end
      end
   endtask

   task automatic test_run_req();
      bus.req_a = 4'b0100;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 5) bus.req_a = '0;
         if (c == 2 || c == 3) begin
            checks++;
            if (bus.rst_dom_o !== ((c == 3) ? 3'b111 : 3'b000)) begin
               errors++;
               $display("FAIL run_req_latency c=%0d: dom=%b want %b", c, bus.rst_dom_o,
                        (c == 3) ? 3'b111 : 3'b000);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.cause_o !== 4'b0100) begin
               errors++;
               $display("FAIL run_req_cause: cause=%b want 0100", bus.cause_o);
            end
         end
         checks++;
         if (bus.rst_dom_o !== m_dom || bus.cause_o !== m_cause || bus.busy_o !== m_busy) begin
            errors++;
            $display("FAIL run_req c=%0d: dom=%b cause=%b busy=%b want %b %b %b", c,
                     bus.rst_dom_o, bus.cause_o, bus.busy_o, m_dom, m_cause, m_busy);
         end
      end
   endtask

   task automatic test_masked();
      bus.req_mask = 4'b1101;
      bus.req_a    = 4'b0010;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 10) bus.req_a = '0;
         checks++;
         if (bus.rst_dom_o !== 3'b000 || bus.cause_o !== 4'b0100 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL masked c=%0d: dom=%b cause=%b busy=%b want 000 0100 0", c,
                     bus.rst_dom_o, bus.cause_o, bus.busy_o);
         end
      end
      bus.req_mask = '1;
   endtask

   task automatic test_release_req();
      int n = 0;
      bus.req_a = 4'b0001;
      @(negedge clk);
      bus.req_a = '0;
      while (bus.rst_dom_o !== 3'b100 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.rst_dom_o !== 3'b100) begin
         errors++;
         $display("FAIL release_reach: dom=%b want 100 within 60 cycles", bus.rst_dom_o);
      end
      bus.req_a = 4'b0001;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 2) bus.req_a = '0;
         if (c == 3) begin
            checks++;
            if (bus.rst_dom_o !== 3'b111) begin
               errors++;
               $display("FAIL release_reassert: dom=%b want 111", bus.rst_dom_o);
            end
         end
         checks++;
         if (bus.rst_dom_o !== m_dom || bus.cause_o !== m_cause || bus.busy_o !== m_busy) begin
            errors++;
            $display("FAIL release_req c=%0d: dom=%b cause=%b busy=%b want %b %b %b", c,
                     bus.rst_dom_o, bus.cause_o, bus.busy_o, m_dom, m_cause, m_busy);
         end
      end
   endtask

   task automatic test_stretch_restart();
      int n = 0;
      bus.req_a = 4'b1000;
      @(negedge clk);
      bus.req_a = '0;
      while (quiet != 10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus.req_a = 4'b1000;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 1) bus.req_a = '0;
         checks++;
         if (bus.rst_dom_o !== m_dom || bus.cause_o !== m_cause || bus.busy_o !== m_busy) begin
            errors++;
            $display("FAIL stretch_restart c=%0d: dom=%b cause=%b busy=%b want %b %b %b", c,
                     bus.rst_dom_o, bus.cause_o, bus.busy_o, m_dom, m_cause, m_busy);
         end
      end
   endtask

   task automatic test_cause_clr();
      bus.req_a = 4'b0001;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         bus.req_a     = '0;
         bus.cause_clr = (c == 2 || c == 3);
         if (c == 3 || c == 4) begin
            checks++;
            if (bus.cause_o !== ((c == 3) ? 4'b0001 : 4'b0000)) begin
               errors++;
               $display("FAIL cause_clr c=%0d: cause=%b want %b", c, bus.cause_o,
                        (c == 3) ? 4'b0001 : 4'b0000);
            end
         end
         checks++;
         if (bus.rst_dom_o !== m_dom || bus.cause_o !== m_cause || bus.busy_o !== m_busy) begin
            errors++;
            $display("FAIL cause_model c=%0d: dom=%b cause=%b busy=%b want %b %b %b", c,
                     bus.rst_dom_o, bus.cause_o, bus.busy_o, m_dom, m_cause, m_busy);
         end
      end
      bus.cause_clr = 1'b0;
   endtask

   task automatic test_rst_mid_release();
      int n = 0;
      while (bus.rst_dom_o !== 3'b110 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.rst_dom_o !== 3'b110) begin
         errors++;
         $display("FAIL rst_mid_reach: dom=%b want 110 within 60 cycles", bus.rst_dom_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.rst_dom_o !== 3'b111 || bus.busy_o !== 1'b1 || bus.cause_o !== 4'h0) begin
         errors++;
         $display("FAIL rst_mid_release: dom=%b busy=%b cause=%h want 111 1 0",
                  bus.rst_dom_o, bus.busy_o, bus.cause_o);
      end
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         checks++;
         if (bus.rst_dom_o !== m_dom || bus.cause_o !== m_cause || bus.busy_o !== m_busy) begin
            errors++;
            $display("FAIL rst_recover c=%0d: dom=%b cause=%b busy=%b want %b %b %b", c,
                     bus.rst_dom_o, bus.cause_o, bus.busy_o, m_dom, m_cause, m_busy);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 19) == 0)
            bus.req_a = ($urandom_range(0, 3) == 0) ? NReq'($urandom) : '0;
         if ($urandom_range(0, 199) == 0) bus.req_mask = NReq'($urandom);
         bus.cause_clr = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 399) == 0);
         @(negedge clk);
         checks++;
         if (bus.rst_dom_o !== m_dom || bus.cause_o !== m_cause || bus.busy_o !== m_busy) begin
            errors++;
            $display("FAIL random c=%0d: dom=%b cause=%b busy=%b want %b %b %b", c,
                     bus.rst_dom_o, bus.cause_o, bus.busy_o, m_dom, m_cause, m_busy);
         end
      end
      rst           = 1'b0;
      bus.req_a     = '0;
      bus.cause_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_run_req();
      test_masked();
      test_release_req();
      test_stretch_restart();
      test_cause_clr();
      bus.req_a = 4'b0010;
      @(negedge clk);
      bus.req_a = '0;
      test_rst_mid_release();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
